mem_bus_responder: RTL
======================

Name: mem_bus_responder

Overview:
- Memory-side responder for the stage-2 bus controls of the control unit.
- Accepts a read request (`mem_assert_main`) or write request (`mem_load_main`) with a resolved 16-bit address from the address mux.
- Runs an external SRAM cycle with programmable wait states, presents `ready`, and holds read data on the main bus until the control unit returns `mem_ack`.
- Drives `stall` so the pipeline freezes while an access is outstanding.

Parameters:
- WIDTH, 8, main bus / SRAM data width
- ADDR_WIDTH, 16, address bus width
- WAIT_STATES, 2, extra SRAM cycles per access (0..15)
- TIMEOUT, 32, cycles to wait for mem_ack before forced release (used only with RESP_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- mem_assert_main  in  1  read request: memory drives main bus
- mem_load_main  in  1  write request: memory loads from main bus
- mem_ack  in  1  control unit has consumed the read data / observed write completion
- addr_in  in  ADDR_WIDTH  resolved address (pcra0/pcra1/sp/si/di/tx)
- bus_in  in  WIDTH  main bus write data
- bus_out  out  WIDTH  read data toward main bus
- bus_out_en  out  1  responder is driving main bus
- ready  out  1  access complete, data valid (reads) / write committed
- stall  out  1  pipeline hold request
- bus_error  out  1  one-cycle pulse on illegal request
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  WIDTH  SRAM write data
- sram_rdata  in  WIDTH  SRAM read data
- sram_oe  out  1  SRAM output enable
- sram_we  out  1  SRAM write enable

Behaviour:
- States: IDLE, SETUP, WAIT, DONE.
- Reset (synchronous, active-high, priority over everything): state=IDLE, wait counter=0; all outputs 0 (bus_out=0, bus_out_en=0, ready=0, stall=0, bus_error=0, sram_* =0). Reset mid-access aborts it, and sram_we drops the same edge.
- IDLE:
  - Read or write alone -> latch addr_in (and bus_in for writes) into sram_addr/sram_wdata, set stall=1, go SETUP.
  - Both read and write high -> bus_error=1 for one cycle, no access, stay IDLE.
- SETUP: one cycle.
  - Read: sram_oe=1. Write: sram_we=0, for address/data setup.
  - Load counter with WAIT_STATES, go WAIT.
- WAIT:
  - Read: sram_oe=1. Write: sram_we=1.
  - Counter decrements each cycle. At counter==0: capture sram_rdata into bus_out (reads), drop sram_we/sram_oe, go DONE.
  - WAIT_STATES=0 means WAIT lasts exactly one cycle.
- DONE:
  - ready=1. Reads: bus_out_en=1.
  - stall=0 in the first DONE cycle, so stage 2 can proceed.
  - On mem_ack=1: next cycle ready=0, bus_out_en=0, go IDLE.
  - Requests seen while not in IDLE are ignored. The control unit must deassert a request before or with mem_ack.
- Latency:
  - Request to ready = WAIT_STATES+2 cycles.
  - Back-to-back access: new request accepted in the IDLE cycle after mem_ack, so minimum period is WAIT_STATES+4 cycles.
- mem_ack while not in DONE: ignored, no error.
- Address and data are latched in IDLE only. Changes to addr_in/bus_in during an access have no effect.
- Address 0xFFFF and 0x0000 are ordinary addresses; there is no wrap logic inside the block.

Optional Feature:
- Macro RESP_TIMEOUT_EN.
- Defined: a second counter runs in DONE. If mem_ack has not arrived after TIMEOUT cycles, pulse bus_error, clear ready/bus_out_en, and go IDLE.
- Not defined: DONE holds indefinitely until mem_ack or reset. bus_error is then only raised for a simultaneous read+write request.

Test Plan:
- Read, WAIT_STATES=2:
  - Stimulus: addr_in=0x1234, sram_rdata=0xA5, mem_assert_main pulse, mem_ack on the cycle after ready.
  - Required: ready high exactly 4 cycles after the request, bus_out=0xA5 with bus_out_en=1, back to IDLE one cycle after mem_ack.
- Write:
  - Stimulus: addr_in=0x00FF, bus_in=0x3C, mem_load_main.
  - Required: sram_addr=0x00FF, sram_wdata=0x3C, sram_we high for 3 cycles (WAIT_STATES+1), never asserted in SETUP, bus_out_en stays 0.
- Illegal request:
  - Stimulus: mem_assert_main and mem_load_main both high in IDLE.
  - Required: bus_error pulse of 1 cycle, sram_oe=sram_we=0, stall=0, state remains IDLE.
- Reset mid-access:
  - Stimulus: reset asserted in WAIT during a write.
  - Required: next edge sram_we=0, stall=0, ready=0. A following read to 0x0001 completes normally.
- Back-to-back with WAIT_STATES=0:
  - Stimulus: read 0xFFFF then write 0x0000, mem_ack at each ready.
  - Required: each ready 2 cycles after its request, second request accepted exactly one cycle after the first mem_ack.
- RESP_TIMEOUT_EN, TIMEOUT=32:
  - Stimulus: read with mem_ack never asserted.
  - Required: ready held 32 cycles, then bus_error pulse, bus_out_en=0, state IDLE.

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: SRAM-side responder for stage-2 bus requests with programmable wait states.
// Optional feature: define RESP_TIMEOUT_EN to force release of DONE after TIMEOUT cycles without mem_ack.
module mem_bus_responder #(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 2,
  parameter int TIMEOUT     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_assert_main,
  input  logic                  mem_load_main,
  input  logic                  mem_ack,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0]      bus_in,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_out_en,
  output logic                  ready,
  output logic                  stall,
  output logic                  bus_error,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WIDTH-1:0]      sram_wdata,
  input  logic [WIDTH-1:0]      sram_rdata,
  output logic                  sram_oe,
  output logic                  sram_we
);

  // Handshake: a lone read or write request is accepted only in IDLE; ready (and bus_out_en
  // for reads) then stays high until mem_ack is sampled, and both drop on the following cycle.
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  state_t     state, next_state;
  logic [3:0] wait_cnt;
  logic       is_read;
  logic       timeout;

`ifdef RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;
  assign timeout = (state == S_DONE) && !mem_ack && (timer == TW'(TIMEOUT - 1));
`else
  // Without the feature DONE is only left on mem_ack or reset.
  assign timeout = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      is_read    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      bus_out    <= '0;
      bus_error  <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      state     <= next_state;
      bus_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_assert_main ^ mem_load_main) begin
            is_read    <= mem_assert_main;
            sram_addr  <= addr_in;
            sram_wdata <= bus_in;
          end
          if (mem_assert_main && mem_load_main) bus_error <= 1'b1;
        end
        S_SETUP: wait_cnt <= WS_CNT;
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (is_read) bus_out <= sram_rdata;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
`ifdef RESP_TIMEOUT_EN
      if (state != S_DONE || mem_ack || timeout) timer <= '0;
      else timer <= timer + 1'b1;
      if (timeout) bus_error <= 1'b1;
`endif
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (mem_assert_main ^ mem_load_main) next_state = S_SETUP;
      S_SETUP: next_state = S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd0) next_state = S_DONE;
      S_DONE:  if (mem_ack || timeout) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Write strobe is withheld in SETUP so address and data settle before sram_we rises.
  always_comb begin
    stall      = 1'b0;
    ready      = 1'b0;
    bus_out_en = 1'b0;
    sram_oe    = 1'b0;
    sram_we    = 1'b0;
    case (state)
      S_SETUP: begin
        stall   = 1'b1;
        sram_oe = is_read;
      end
      S_WAIT: begin
        stall   = 1'b1;
        sram_oe = is_read;
        sram_we = !is_read;
      end
      S_DONE: begin
        ready      = 1'b1;
        bus_out_en = is_read;
      end
      default: ;
    endcase
  end

endmodule
